// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler:
// FSM encoding, ALU opcode values and ALU flag bit positions.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_SUB   = 2'b00;
  localparam logic [1:0] OP_NAND  = 2'b01;
  localparam logic [1:0] OP_SONES = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  localparam int FLG_ERR = 0;
  localparam int FLG_NEG = 1;
  localparam int FLG_POS = 2;
  localparam int FLG_OVF = 3;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps, so the first valid requester found wins.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last) + i) % N_REQ;
      if (!any_valid && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among N_REQ requesters: round-robin accept,
// issue, capture after the ALU's one-cycle latency, then hold a response.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [2*N_REQ-1:0]     i_req_oper,
  input  logic [WIDTH*N_REQ-1:0] i_req_arg0,
  input  logic [WIDTH*N_REQ-1:0] i_req_arg1,
  output logic [WIDTH-1:0]       o_alu_arg0,
  output logic [WIDTH-1:0]       o_alu_arg1,
  output logic [1:0]             o_alu_oper,
  input  logic [WIDTH-1:0]       i_alu_result,
  input  logic [3:0]             i_alu_flag,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [WIDTH-1:0]       o_rsp_result,
  output logic [3:0]             o_rsp_flag,
  output logic                   o_busy,
  output logic [7:0]             o_err_cnt,
  output logic [1:0]             o_dbg_state
);

  // Handshakes: a request transfers on a cycle where valid and ready are both
  // high; ready is only ever raised in IDLE and only for the granted requester.
  // A response transfers on a cycle where o_rsp_valid and i_rsp_ready are high.

  state_t state_q, state_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  g_idx;
  logic             any_valid;
  logic             accept;

  logic [1:0]       issue_oper_q;
  logic [WIDTH-1:0] issue_arg0_q;
  logic [WIDTH-1:0] issue_arg1_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  last_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flag_q;
  logic [7:0]       err_cnt_q;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (i_req_valid),
    .last     (last_q),
    .grant    (grant),
    .idx      (g_idx),
    .any_valid(any_valid)
  );

  // Gated by reset so no requester sees ready while the block is held in reset.
  assign accept      = (state_q == S_IDLE) && any_valid && i_rstn;
  assign o_req_ready = accept ? grant : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_CAPT;
      S_CAPT:  state_d = S_RESP;
      S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      issue_oper_q <= '0;
      issue_arg0_q <= '0;
      issue_arg1_q <= '0;
      id_q         <= '0;
      last_q       <= ID_W'(N_REQ - 1);
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        issue_oper_q <= i_req_oper[int'(g_idx)*2 +: 2];
        issue_arg0_q <= i_req_arg0[int'(g_idx)*WIDTH +: WIDTH];
        issue_arg1_q <= i_req_arg1[int'(g_idx)*WIDTH +: WIDTH];
        id_q         <= g_idx;
        last_q       <= g_idx;
      end
      if (state_q == S_CAPT) begin
        rsp_result_q <= i_alu_result;
        rsp_flag_q   <= i_alu_flag;
        if (i_alu_flag[FLG_ERR] && (err_cnt_q != ERR_CNT_MAX))
          err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign o_alu_oper   = issue_oper_q;
  assign o_alu_arg0   = issue_arg0_q;
  assign o_alu_arg1   = issue_arg1_q;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_rsp_id     = id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_flag   = rsp_flag_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_err_cnt    = err_cnt_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one registered ALU instance among `N_REQ` independent requesters. It accepts one operation at a time over a valid/ready request handshake, drives the ALU operand and opcode inputs, and captures the ALU result and flags after the ALU's one-cycle register latency. It returns the result to the requester over a valid/ready response channel tagged with the requester id. It also keeps a saturating count of error-flagged results. It sits between the requester fabric and the ALU top, which it instantiates externally (ports only).

## Interface
- `WIDTH`, 4, operand/result width; must equal the ALU `WIDTH`.
- `N_REQ`, 3, number of requesters; legal range 2..4.
- `ID_W`, 2, requester id width; must satisfy `2**ID_W >= N_REQ`.
- `i_clk`  in  1  clock
- `i_rstn`  in  1  reset, asynchronous, active-low
- `i_req_valid`  in  `N_REQ`  per-requester request valid
- `o_req_ready`  out  `N_REQ`  per-requester accept strobe; one-hot or zero
- `i_req_oper`  in  `2*N_REQ`  opcodes, flat; requester k at `[2k+1:2k]`
- `i_req_arg0`  in  `WIDTH*N_REQ`  first operands, flat, signed
- `i_req_arg1`  in  `WIDTH*N_REQ`  second operands, flat, signed
- `o_alu_arg0`  out  `WIDTH`  to ALU `i_arg0`
- `o_alu_arg1`  out  `WIDTH`  to ALU `i_arg1`
- `o_alu_oper`  out  2  to ALU `i_oper`
- `i_alu_result`  in  `WIDTH`  from ALU `o_result` (registered in the ALU)
- `i_alu_flag`  in  4  from ALU `o_flag`: bit0 err, bit1 neg, bit2 pos, bit3 overflow
- `o_rsp_valid`  out  1  response valid
- `i_rsp_ready`  in  1  response accept
- `o_rsp_id`  out  `ID_W`  id of the requester that issued the operation
- `o_rsp_result`  out  `WIDTH`  captured result
- `o_rsp_flag`  out  4  captured flags
- `o_busy`  out  1  high in every state except `IDLE`
- `o_err_cnt`  out  8  saturating count of responses with flag bit0 set

## Operation
- FSM states: `IDLE`, `EXEC`, `CAPT`, `RESP`.
- `IDLE`:
  - If any `i_req_valid` bit is set, the arbiter grants one requester: search starts at `last+1` and wraps.
  - Set `o_req_ready[g]=1` (combinational) for the granted requester only.
  - Latch that requester's opcode and operands into the issue registers, latch `g` into the id register and `last`, then go to `EXEC`.
  - If no request is valid, stay in `IDLE`.
- `EXEC`: the ALU inputs show the issue registers; the ALU registers its output at the end of this cycle. Go to `CAPT`.
- `CAPT`:
  - Latch `i_alu_result`/`i_alu_flag` into the response registers.
  - If `i_alu_flag[0]` is set, increment `o_err_cnt`, saturating at 255.
  - Go to `RESP`.
- `RESP`: `o_rsp_valid=1`; response fields held stable. On `i_rsp_ready=1`, go to `IDLE`; otherwise stay.
- `o_alu_*` are driven from the issue registers in all states. They hold their last value in `IDLE` and are never driven directly from request inputs.
- Requesters must hold `valid` and payload until `ready`. Dropping `valid` without `ready` is legal; such a requester is simply not granted.
- Requests arriving in any state other than `IDLE` wait; `o_req_ready` is 0 outside `IDLE`.
- Opcodes pass through unchanged: 00 sub, 01 nand, 10 starting-ones, 11 one-hot decode.

## Timing
- Reset values: state `IDLE`; `last = N_REQ-1`, so requester 0 wins first; all issue/response registers 0; `o_rsp_valid=0`; `o_err_cnt=0`; `o_busy=0`; `o_req_ready=0`.
- Reset asserted mid-operation: the operation in flight is discarded with no response.
- Accept at cycle T (`IDLE`, ready high) → `EXEC` T+1 → `CAPT` T+2 → `o_rsp_valid` first high at T+3.
- If `i_rsp_ready` is high at T+3, the next accept occurs at T+4. Peak throughput is one operation per 4 cycles.
- Simultaneous requests: exactly one grant, in round-robin order. No requester waits more than `N_REQ-1` grants.
- `o_err_cnt` saturates at 255 and never wraps.

## Structure
- Package `alu_sched_pkg`:
  - FSM state encoding
  - opcode constants (`OP_SUB`, `OP_NAND`, `OP_SONES`, `OP_DEC`)
  - flag bit indices (`FLG_ERR`, `FLG_NEG`, `FLG_POS`, `FLG_OVF`)
- One sub-module, `rr_arbiter`, parameterised by `N_REQ`:
  - inputs: request vector, `last` pointer
  - outputs: one-hot grant, encoded index, any-valid
  - purely combinational
- FSM, registers and counter live in the top `alu_rr_scheduler`.

## Test plan
- Single request: requester 0, oper 00, arg0=5, arg1=3 → ready at T; response at T+3 with result 2, flag 4'b0100, id 0.
- Negative result: requester 1, oper 00, 3−5 → result 4'b1110, flag 4'b0010, id 1.
- All three requesters valid continuously after reset → grant order 0,1,2,0,1,2, with accepts 4 cycles apart while `i_rsp_ready` is tied high.
- Response backpressure: `i_rsp_ready` held low for 10 cycles →
  - `o_rsp_valid` and all response fields stay stable;
  - `o_req_ready` stays 0;
  - the next accept is 1 cycle after the ready handshake.
- Error counting: 260 operations with `i_alu_flag[0]` forced to 1 → `o_err_cnt` reaches 255 and holds.
- Reset asserted in `CAPT` → all outputs return to their reset values immediately; no response is issued; requester 0 is granted first afterward.
